snoop_bus_controller: RTL and testbench

Bus-side responder for the MESI multiprocessor: the single agent at the far end of every cache's bus interface. It arbitrates read-miss, write-miss, invalidate and write-back requests from the processors and broadcasts each winning request as a snoop. It collects snoop hit/abort responses, supplies fill data from its internal 32x8 main memory or from an aborting owner's write-back, and returns a one-cycle acknowledge with data and a shared indication.

---
 rtl/snoop_bus_controller.sv | 170 +++++++++++++++++
 tb/tb_snoop_bus_controller.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/snoop_bus_controller.sv
// MESI bus responder: round-robin arbitration, snoop broadcast, fill from memory or an aborting owner.
// Ack latency after grant is 1 (write-back), 3 (invalidate/abort) or 4 (memory read); losers hold req until granted.
module snoop_bus_controller #(
  parameter int NPROC  = 3,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NPROC-1:0]        req,
  input  logic [2*NPROC-1:0]      req_op,
  input  logic [ADDR_W*NPROC-1:0] req_addr,
  input  logic [DATA_W*NPROC-1:0] req_data,
  output logic [NPROC-1:0]        ack,
  output logic [DATA_W-1:0]       rdata,
  output logic                    rshared,
  output logic                    snoop_valid,
  output logic [1:0]              snoop_op,
  output logic [ADDR_W-1:0]       snoop_addr,
  output logic [NPROC-1:0]        snoop_src,
  input  logic [NPROC-1:0]        snoop_hit,
  input  logic [NPROC-1:0]        snoop_abort,
  input  logic [DATA_W*NPROC-1:0] snoop_data,
  output logic                    busy
);

  localparam int IDX_W = (NPROC > 1) ? $clog2(NPROC) : 1;

  localparam logic [1:0] OP_RD  = 2'd0;
  localparam logic [1:0] OP_INV = 2'd2;
  localparam logic [1:0] OP_WB  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_SNOOP, S_COLLECT, S_MEMRD, S_DONE
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   win_q;
  logic [DATA_W-1:0]  mem [2**ADDR_W];

  logic               found;
  logic [IDX_W-1:0]   win_idx;
  logic [1:0]         win_op;
  logic [ADDR_W-1:0]  win_addr;
  logic [DATA_W-1:0]  win_data;
  logic [NPROC-1:0]   win_onehot;
  logic [NPROC-1:0]   hit_m;
  logic [NPROC-1:0]   abort_m;
  logic               abort_any;
  logic               abort_found;
  logic [DATA_W-1:0]  abort_dat;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_waddr;
  logic [DATA_W-1:0]  mem_wdata;

  // Round-robin: search starts one past the last granted processor.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    for (int k = 1; k <= NPROC; k++) begin
      if (!found && req[(int'(last_grant) + k) % NPROC]) begin
        found   = 1'b1;
        win_idx = IDX_W'((int'(last_grant) + k) % NPROC);
      end
    end
    win_op     = req_op[2*int'(win_idx) +: 2];
    win_addr   = req_addr[ADDR_W*int'(win_idx) +: ADDR_W];
    win_data   = req_data[DATA_W*int'(win_idx) +: DATA_W];
    win_onehot = NPROC'(1) << win_idx;
  end

  // The requester's own snoop response is masked out; lowest-index owner supplies data.
  always_comb begin
    hit_m       = snoop_hit & ~snoop_src;
    abort_m     = snoop_abort & ~snoop_src;
    abort_any   = |abort_m;
    abort_found = 1'b0;
    abort_dat   = '0;
    for (int i = 0; i < NPROC; i++) begin
      if (!abort_found && abort_m[i]) begin
        abort_found = 1'b1;
        abort_dat   = snoop_data[DATA_W*i +: DATA_W];
      end
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = win_addr;
    mem_wdata = win_data;
    if (state == S_IDLE && found && win_op == OP_WB) begin
      mem_we = 1'b1;
    end else if (state == S_COLLECT && snoop_op != OP_INV && abort_any) begin
      mem_we    = 1'b1;
      mem_waddr = snoop_addr;
      mem_wdata = abort_dat;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we && !reset) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      last_grant  <= IDX_W'(NPROC-1);
      win_q       <= '0;
      ack         <= '0;
      rdata       <= '0;
      rshared     <= 1'b0;
      snoop_valid <= 1'b0;
      snoop_op    <= '0;
      snoop_addr  <= '0;
      snoop_src   <= '0;
      busy        <= 1'b0;
    end else begin
      snoop_valid <= 1'b0;
      ack         <= '0;
      case (state)
        S_IDLE: begin
          if (found) begin
            win_q      <= win_idx;
            snoop_op   <= win_op;
            snoop_addr <= win_addr;
            snoop_src  <= win_onehot;
            rshared    <= 1'b0;
            busy       <= 1'b1;
            if (win_op == OP_WB) begin
              ack   <= win_onehot;
              state <= S_DONE;
            end else begin
              snoop_valid <= 1'b1;
              state       <= S_SNOOP;
            end
          end
        end
        S_SNOOP: state <= S_COLLECT;
        S_COLLECT: begin
          if (snoop_op == OP_INV) begin
            ack   <= snoop_src;
            state <= S_DONE;
          end else begin
            rshared <= (snoop_op == OP_RD) && ((|hit_m) || abort_any);
            if (abort_any) begin
              rdata <= abort_dat;
              ack   <= snoop_src;
              state <= S_DONE;
            end else begin
              state <= S_MEMRD;
            end
          end
        end
        S_MEMRD: begin
          rdata <= mem[snoop_addr];
          ack   <= snoop_src;
          state <= S_DONE;
        end
        S_DONE: begin
          last_grant <= win_q;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snoop_bus_controller.sv
// Directed bench for snoop_bus_controller: hand-computed latencies, fill data and shared flags.
module tb_snoop_bus_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [5:0]  req_op;
  logic [14:0] req_addr;
  logic [23:0] req_data;
  logic [2:0]  ack;
  logic [7:0]  rdata;
  logic        rshared;
  logic        snoop_valid;
  logic [1:0]  snoop_op;
  logic [4:0]  snoop_addr;
  logic [2:0]  snoop_src;
  logic [2:0]  snoop_hit;
  logic [2:0]  snoop_abort;
  logic [23:0] snoop_data;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;

  snoop_bus_controller dut (
    .clock(clock), .reset(reset), .req(req), .req_op(req_op), .req_addr(req_addr),
    .req_data(req_data), .ack(ack), .rdata(rdata), .rshared(rshared),
    .snoop_valid(snoop_valid), .snoop_op(snoop_op), .snoop_addr(snoop_addr),
    .snoop_src(snoop_src), .snoop_hit(snoop_hit), .snoop_abort(snoop_abort),
    .snoop_data(snoop_data), .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Starts in an IDLE cycle (cycle 0), returns in the IDLE cycle after the ack.
  task automatic run_req(input string tag, input int p, input logic [1:0] op,
                         input logic [4:0] addr, input logic [7:0] wdata,
                         input logic [2:0] hit, input logic [2:0] abort, input logic [23:0] sdata,
                         input int exp_lat, input logic chk_data,
                         input logic [7:0] exp_rdata, input logic exp_sh);
    int lat;
    lat = 0;
    req_op[2*p +: 2]   = op;
    req_addr[5*p +: 5] = addr;
    req_data[8*p +: 8] = wdata;
    snoop_hit   = hit;
    snoop_abort = abort;
    snoop_data  = sdata;
    req[p]      = 1'b1;
    for (int n = 1; n <= 8 && lat == 0; n++) begin
      tick();
      if (n == 1) check({tag, " busy"}, 32'(busy), 32'd1);
      if (n == 1 && op != 2'd3) begin
        check({tag, " snoop_valid c1"}, 32'(snoop_valid), 32'd1);
        check({tag, " snoop_src"}, 32'(snoop_src), 32'(3'b001 << p));
        check({tag, " snoop_addr"}, 32'(snoop_addr), 32'(addr));
        check({tag, " snoop_op"}, 32'(snoop_op), 32'(op));
      end
      if (n == 2 && op != 2'd3) check({tag, " snoop_valid c2"}, 32'(snoop_valid), 32'd0);
      if (ack != 3'b000) lat = n;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " ack"}, 32'(ack), 32'(3'b001 << p));
    if (chk_data) begin
      check({tag, " rdata"}, 32'(rdata), 32'(exp_rdata));
      check({tag, " rshared"}, 32'(rshared), 32'(exp_sh));
    end
    req[p]      = 1'b0;
    snoop_hit   = '0;
    snoop_abort = '0;
    snoop_data  = '0;
    tick();
    check({tag, " ack pulse width"}, 32'(ack), 32'd0);
    check({tag, " idle busy"}, 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " ack"}, 32'(ack), 32'd0);
    check({tag, " rdata"}, 32'(rdata), 32'd0);
    check({tag, " rshared"}, 32'(rshared), 32'd0);
    check({tag, " snoop_valid"}, 32'(snoop_valid), 32'd0);
    check({tag, " snoop_op"}, 32'(snoop_op), 32'd0);
    check({tag, " snoop_addr"}, 32'(snoop_addr), 32'd0);
    check({tag, " snoop_src"}, 32'(snoop_src), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [2:0] rr_seq [4];
    rr_seq[0] = 3'b001; rr_seq[1] = 3'b010; rr_seq[2] = 3'b100; rr_seq[3] = 3'b001;

    reset = 1'b1; req = '0; req_op = '0; req_addr = '0; req_data = '0;
    snoop_hit = '0; snoop_abort = '0; snoop_data = '0;
    tick(); tick();
    reset = 1'b0;
    check_reset_outputs("reset");

    // tag, p, op, addr, wdata, hit, abort, sdata, lat, chk, rdata, shared
    run_req("wb p0",       0, 2'd3, 5'd5,  8'hA7, 3'b000, 3'b000, 24'h0,      1, 1'b0, 8'h00, 1'b0);
    run_req("rd p1 nohit", 1, 2'd0, 5'd5,  8'h00, 3'b000, 3'b000, 24'h0,      4, 1'b1, 8'hA7, 1'b0);
    run_req("rd p2 hit",   2, 2'd0, 5'd5,  8'h00, 3'b010, 3'b000, 24'h0,      4, 1'b1, 8'hA7, 1'b1);
    run_req("rd p0 abort", 0, 2'd0, 5'd9,  8'h00, 3'b000, 3'b100, 24'h3C0000, 3, 1'b1, 8'h3C, 1'b1);
    run_req("rd p1 own",   1, 2'd0, 5'd9,  8'h00, 3'b010, 3'b000, 24'h0,      4, 1'b1, 8'h3C, 1'b0);
    run_req("inv p1",      1, 2'd2, 5'd5,  8'h00, 3'b111, 3'b000, 24'h0,      3, 1'b1, 8'h3C, 1'b0);
    run_req("rd after inv",2, 2'd0, 5'd5,  8'h00, 3'b000, 3'b000, 24'h0,      4, 1'b1, 8'hA7, 1'b0);
    run_req("wm p0",       0, 2'd1, 5'd5,  8'h00, 3'b110, 3'b000, 24'h0,      4, 1'b1, 8'hA7, 1'b0);

    // All three hold write-back requests from a fresh reset.
    reset = 1'b1; tick(); reset = 1'b0;
    req_op   = {2'd3, 2'd3, 2'd3};
    req_addr = {5'd22, 5'd21, 5'd20};
    req_data = {8'h33, 8'h22, 8'h11};
    req      = 3'b111;
    for (int n = 1; n <= 7; n++) begin
      tick();
      if (n % 2 == 1) check($sformatf("rr ack c%0d", n), 32'(ack), 32'(rr_seq[(n-1)/2]));
      else            check($sformatf("rr gap c%0d", n), 32'(ack), 32'd0);
    end
    req = '0;
    tick();
    check("rr idle busy", 32'(busy), 32'd0);
    run_req("rd rr addr21", 1, 2'd0, 5'd21, 8'h00, 3'b000, 3'b000, 24'h0, 4, 1'b1, 8'h22, 1'b0);

    // Reset lands on the COLLECT edge of a read miss with an abort.
    req_op[1:0] = 2'd0; req_addr[4:0] = 5'd22;
    snoop_abort = 3'b010; snoop_data = 24'h009900;
    req[0] = 1'b1;
    tick();
    tick();
    reset = 1'b1; req = '0;
    tick();
    check_reset_outputs("mid reset");
    reset = 1'b0; snoop_abort = '0; snoop_data = '0;
    tick();
    check("mid reset no ack", 32'(ack), 32'd0);
    run_req("rd after reset", 2, 2'd0, 5'd22, 8'h00, 3'b000, 3'b000, 24'h0, 4, 1'b1, 8'h33, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
